rkv_seq_chk: RTL and testbench



---
 rtl/rkv_seq_chk_pkg.sv | 21 ++
 rtl/rkv_sat_cnt.sv | 33 +++
 rtl/rkv_seq_chk.sv | 166 ++++++++++++++++
 tb/tb_rkv_seq_chk.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rkv_seq_chk_pkg.sv
// Shared types and the expected-next-value helper for the rkv_seq_chk stream checker.
package rkv_seq_chk_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LOCK, ST_TRACK, ST_DONE} state_e;
  typedef enum logic [1:0] {MODE_NONE, MODE_INC, MODE_SHL} mode_e;

  localparam int unsigned MaxDw = 32;

  // Callers truncate the result to their own width, which yields mod 2^DW behaviour.
  function automatic logic [MaxDw-1:0] next_exp(input mode_e m, input logic [MaxDw-1:0] prev);
    logic [MaxDw-1:0] res;
    res = prev;
    unique case (m)
      MODE_INC: res = prev + 32'd1;
      MODE_SHL: res = prev << 1;
      default:  res = prev;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rkv_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module rkv_sat_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rkv_seq_chk.sv
// Stream checker: locks onto an increment or one-hot shift pattern and counts deviations.
// Optional first-mismatch capture ports are enabled by defining RKV_SEQ_CHK_FIRST_ERR_EN.
module rkv_seq_chk
  import rkv_seq_chk_pkg::*;
#(
  parameter int unsigned DW = 4,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  output logic [1:0]    mode,
  output logic          locked,
  output logic          err_pulse,
  output logic [CW-1:0] err_cnt,
  output logic          done
`ifdef RKV_SEQ_CHK_FIRST_ERR_EN
  ,
  output logic [DW-1:0] first_err_exp,
  output logic [DW-1:0] first_err_act,
  output logic          first_err_vld
`endif
);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [DW-1:0] prev_q, prev_d;
  logic          locked_q, locked_d;
  logic          err_pulse_q, err_pulse_d;
  logic          done_q, done_d;
  logic          cnt_inc;

  logic [DW-1:0] exp_inc, exp_shl, exp_trk;
  logic          inc_hit, shl_hit, mismatch, terminal;

  assign exp_inc  = DW'(next_exp(MODE_INC, MaxDw'(prev_q)));
  assign exp_shl  = DW'(next_exp(MODE_SHL, MaxDw'(prev_q)));
  assign exp_trk  = DW'(next_exp(mode_q, MaxDw'(prev_q)));
  assign inc_hit  = (in_data == exp_inc);
  assign shl_hit  = (prev_q != '0) && (in_data == exp_shl);
  assign mismatch = (in_data != exp_trk);
  // Only a matching sample can be terminal; a stray all-ones or zero is just an error.
  assign terminal = ((mode_q == MODE_INC) && (in_data == {DW{1'b1}})) ||
                    ((mode_q == MODE_SHL) && (in_data == '0));

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    prev_d      = prev_q;
    err_pulse_d = 1'b0;
    done_d      = done_q;
    cnt_inc     = 1'b0;
    if (clr) begin
      state_d = ST_IDLE;
      mode_d  = MODE_NONE;
      prev_d  = '0;
      done_d  = 1'b0;
    end else if (in_vld) begin
      unique case (state_q)
        ST_IDLE: begin
          prev_d  = in_data;
          state_d = ST_LOCK;
        end
        ST_LOCK: begin
          prev_d = in_data;
          // Ambiguous (1 -> 2) or unrelated pairs keep searching without flagging an error.
          if (inc_hit && !shl_hit) begin
            mode_d  = MODE_INC;
            state_d = ST_TRACK;
          end else if (shl_hit && !inc_hit) begin
            mode_d  = MODE_SHL;
            state_d = ST_TRACK;
          end
        end
        ST_TRACK: begin
          prev_d = in_data;
          if (mismatch) begin
            err_pulse_d = 1'b1;
            cnt_inc     = 1'b1;
          end else if (terminal) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    locked_d = (state_d == ST_TRACK) || (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_NONE;
      prev_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      prev_q      <= prev_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      done_q      <= done_d;
    end
  end

  rkv_sat_cnt #(
    .Width(CW)
  ) u_err_cnt (
    .clk_i (clk),
    .rst_ni(rstn),
    .clr_i (clr),
    .inc_i (cnt_inc),
    .cnt_o (err_cnt)
  );

  assign mode      = mode_q;
  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign done      = done_q;

`ifdef RKV_SEQ_CHK_FIRST_ERR_EN
  logic [DW-1:0] fe_exp_q, fe_exp_d;
  logic [DW-1:0] fe_act_q, fe_act_d;
  logic          fe_vld_q, fe_vld_d;

  always_comb begin
    fe_exp_d = fe_exp_q;
    fe_act_d = fe_act_q;
    fe_vld_d = fe_vld_q;
    if (clr) begin
      fe_exp_d = '0;
      fe_act_d = '0;
      fe_vld_d = 1'b0;
    end else if (cnt_inc && !fe_vld_q) begin
      fe_exp_d = exp_trk;
      fe_act_d = in_data;
      fe_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fe_exp_q <= '0;
      fe_act_q <= '0;
      fe_vld_q <= 1'b0;
    end else begin
      fe_exp_q <= fe_exp_d;
      fe_act_q <= fe_act_d;
      fe_vld_q <= fe_vld_d;
    end
  end

  assign first_err_exp = fe_exp_q;
  assign first_err_act = fe_act_q;
  assign first_err_vld = fe_vld_q;
`endif

endmodule

// File: tb/tb_rkv_seq_chk.sv
// Self-checking bench for rkv_seq_chk: directed plan steps plus randomized streams vs a model.
module tb_rkv_seq_chk;

  localparam int DW = 4;
  localparam int CW = 8;
  localparam int Mod = 1 << DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, clr, in_vld;
  logic [DW-1:0] in_data;
  logic [1:0]    mode, mode_s;
  logic          locked, locked_s, err_pulse, err_pulse_s, done, done_s;
  logic [CW-1:0] err_cnt;
  logic [1:0]    err_cnt_s;
`ifdef RKV_SEQ_CHK_FIRST_ERR_EN
  logic [DW-1:0] fe_exp, fe_act, fe_exp_s, fe_act_s;
  logic          fe_vld, fe_vld_s;
`endif

  rkv_seq_chk #(.DW(DW), .CW(CW)) u_dut (
    .clk(clk), .rstn(rstn), .clr(clr), .in_vld(in_vld), .in_data(in_data),
    .mode(mode), .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .done(done)
`ifdef RKV_SEQ_CHK_FIRST_ERR_EN
    , .first_err_exp(fe_exp), .first_err_act(fe_act), .first_err_vld(fe_vld)
`endif
  );

  // Narrow counter copy exercises saturation on the same stimulus.
  rkv_seq_chk #(.DW(DW), .CW(2)) u_sat (
    .clk(clk), .rstn(rstn), .clr(clr), .in_vld(in_vld), .in_data(in_data),
    .mode(mode_s), .locked(locked_s), .err_pulse(err_pulse_s), .err_cnt(err_cnt_s),
    .done(done_s)
`ifdef RKV_SEQ_CHK_FIRST_ERR_EN
    , .first_err_exp(fe_exp_s), .first_err_act(fe_act_s), .first_err_vld(fe_vld_s)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model in terms of the behavioural rules.
  bit m_seen, m_locked, m_done, m_pulse, m_fvld;
  int m_mode, m_prev, m_cnt, m_cnt_s, m_fexp, m_fact;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
  endtask

  task automatic model_clear();
    m_seen = 0; m_locked = 0; m_done = 0; m_pulse = 0; m_fvld = 0;
    m_mode = 0; m_prev = 0; m_cnt = 0; m_cnt_s = 0; m_fexp = 0; m_fact = 0;
  endtask

  task automatic model_step(input bit r, input bit c, input bit v, input int d);
    int e;
    bit inc, shl;
    m_pulse = 0;
    if (!r || c) begin
      model_clear();
    end else if (v && !m_done) begin
      if (!m_seen) begin
        m_seen = 1;
      end else if (!m_locked) begin
        inc = (d == (m_prev + 1) % Mod);
        shl = (m_prev != 0) && (d == (m_prev * 2) % Mod);
        if (inc != shl) begin
          m_locked = 1;
          m_mode = inc ? 1 : 2;
        end
      end else begin
        e = (m_mode == 1) ? (m_prev + 1) % Mod : (m_prev * 2) % Mod;
        if (d != e) begin
          m_pulse = 1;
          if (m_cnt < (1 << CW) - 1) m_cnt++;
          if (m_cnt_s < 3) m_cnt_s++;
          if (!m_fvld) begin
            m_fvld = 1; m_fexp = e; m_fact = d;
          end
        end else if ((m_mode == 1 && d == Mod - 1) || (m_mode == 2 && d == 0)) begin
          m_done = 1;
        end
      end
      m_prev = d;
    end
  endtask

  task automatic check_all();
    check("mode", 32'(mode), 32'(m_mode));
    check("locked", 32'(locked), 32'(m_locked));
    check("err_pulse", 32'(err_pulse), 32'(m_pulse));
    check("err_cnt", 32'(err_cnt), 32'(m_cnt));
    check("done", 32'(done), 32'(m_done));
    check("err_cnt_cw2", 32'(err_cnt_s), 32'(m_cnt_s));
    check("err_pulse_cw2", 32'(err_pulse_s), 32'(m_pulse));
`ifdef RKV_SEQ_CHK_FIRST_ERR_EN
    check("first_err_vld", 32'(fe_vld), 32'(m_fvld));
    check("first_err_exp", 32'(fe_exp), 32'(m_fexp));
    check("first_err_act", 32'(fe_act), 32'(m_fact));
`endif
  endtask

  task automatic cycle(input bit r, input bit c, input bit v, input int d);
    rstn = r; clr = c; in_vld = v; in_data = d[DW-1:0];
    @(posedge clk);
    model_step(r, c, v, d);
    #1;
    check_all();
  endtask

  task automatic sample(input int d);
    cycle(1'b1, 1'b0, 1'b1, d);
  endtask

  task automatic soft_clr();
    cycle(1'b1, 1'b1, 1'b0, 0);
  endtask

  initial begin
    int d, npulse;
    bit r, c, v, use_shl;
    model_clear();
    rstn = 1'b0; clr = 1'b0; in_vld = 1'b0; in_data = '0;
    cycle(1'b0, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 1'b1, 5);
    check("rst_mode", 32'(mode), 0);
    check("rst_cnt", 32'(err_cnt), 0);

    // INC clean run 0..15.
    for (int i = 0; i < 16; i++) begin
      sample(i);
      if (i == 1) check("inc_mode_after_1", 32'(mode), 1);
    end
    check("inc_done", 32'(done), 1);
    check("inc_no_err", 32'(err_cnt), 0);
    sample(3);
    check("done_ignores", 32'(err_pulse), 0);

    // SHL with ambiguous 1 -> 2 start.
    soft_clr();
    sample(1); sample(2);
    check("shl_amb_unlocked", 32'(locked), 0);
    sample(4);
    check("shl_mode", 32'(mode), 2);
    sample(8); sample(0);
    check("shl_done", 32'(done), 1);

    // TRACK error and resync.
    soft_clr();
    sample(3); sample(4); sample(5); sample(9);
    check("trk_pulse", 32'(err_pulse), 1);
    sample(10);
    check("trk_one_err", 32'(err_cnt), 1);
    check("trk_pulse_low", 32'(err_pulse), 0);
`ifdef RKV_SEQ_CHK_FIRST_ERR_EN
    check("trk_fe_exp", 32'(fe_exp), 6);
    check("trk_fe_act", 32'(fe_act), 9);
`endif

    // Saturation on the CW=2 copy.
    soft_clr();
    sample(3); sample(4);
    npulse = 0;
    for (int i = 0; i < 5; i++) begin
      d = (i == 0) ? 9 : (i == 1) ? 1 : (i == 2) ? 12 : (i == 3) ? 7 : 3;
      sample(d);
      if (err_pulse_s === 1'b1) npulse++;
    end
    check("sat_pulses", 32'(npulse), 5);
    check("sat_cnt_cw2", 32'(err_cnt_s), 3);
    check("sat_cnt_cw8", 32'(err_cnt), 5);

    // clr beats in_vld mid-TRACK.
    soft_clr();
    sample(0); sample(1); sample(2);
    cycle(1'b1, 1'b1, 1'b1, 3);
    check("clr_locked", 32'(locked), 0);
    sample(4); sample(5);
    check("clr_sample_dropped", 32'(mode), 1);

    // rstn pulse mid-SHL, then relock.
    soft_clr();
    sample(1); sample(2); sample(4);
    cycle(1'b0, 1'b0, 1'b1, 4);
    check("rst_mid_locked", 32'(locked), 0);
    sample(4);
    check("rst_relock_wait", 32'(mode), 0);
    sample(8);
    check("rst_relock_shl", 32'(mode), 2);
    sample(0);
    check("rst_relock_done", 32'(done), 1);

    // Randomized streams, mostly on-pattern with injected noise, clears and resets.
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(0, 99) != 0);
      c = ($urandom_range(0, 59) == 0) || (m_done && ($urandom_range(0, 3) == 0));
      v = ($urandom_range(0, 3) != 0);
      use_shl = m_locked ? (m_mode == 2) : ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) < 8) begin
        d = use_shl ? (m_prev * 2) % Mod : (m_prev + 1) % Mod;
        if (use_shl && d == 0 && !m_locked) d = 1;
      end else begin
        d = $urandom_range(0, Mod - 1);
      end
      cycle(r, c, v, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
